// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU function codes, execute-unit FSM states and
// signed-overflow helpers used by the ALU datapath.
package cpu_pkg;

    localparam logic [5:0] FUNCT_ADD = 6'b001001;
    localparam logic [5:0] FUNCT_SUB = 6'b001010;
    localparam logic [5:0] FUNCT_OR  = 6'b010010;
    localparam logic [5:0] FUNCT_SRL = 6'b100010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    // Addition overflows when both operands share a sign the sum does not.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                          input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Subtraction overflows when operand signs differ and the difference
    // takes the sign of the subtrahend instead of the minuend.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_srl_iter.sv
// Iterative logical right shifter: one bit position per clock. A load
// captures the operand and shift count; done is high during the cycle that
// performs the final shift, with shift_out carrying the finished value.
module alu_srl_iter
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DATA_W-1:0]  load_data,
    input  logic [SHAMT_W-1:0] load_shamt,
    output logic               done,
    output logic [DATA_W-1:0]  shift_out
);

    logic [DATA_W-1:0]  shift_r;
    logic [SHAMT_W-1:0] cnt_r;

    // Load operand/count on request, otherwise shift once per cycle until the count runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {DATA_W{1'b0}};
            cnt_r   <= {SHAMT_W{1'b0}};
        end else if (load) begin
            shift_r <= load_data;
            cnt_r   <= load_shamt;
        end else if (cnt_r != {SHAMT_W{1'b0}}) begin
            shift_r <= {1'b0, shift_r[DATA_W-1:1]};
            cnt_r   <= cnt_r - SHAMT_W'(1);
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

    // The cycle with one shift left is the last one; expose its outcome directly.
    always_comb begin
        done      = (cnt_r == SHAMT_W'(1));
        shift_out = {1'b0, shift_r[DATA_W-1:1]};
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU. ADD/SUB/OR complete in one cycle; SRL runs through the
// iterative shifter and stalls the upstream handshake while it works.
// Results and flags are registered and held until the downstream accepts.
module alu_exec_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         funct,
    input  logic [DATA_W-1:0]  src1,
    input  logic [DATA_W-1:0]  src2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               overflow
);

    alu_state_e        state_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] result_r;
    logic              zero_r;
    logic              overflow_r;

    logic              accept_s;
    logic              srl_load_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_ovf_s;
    logic [DATA_W-1:0] sum_s;
    logic [DATA_W-1:0] diff_s;
    logic              srl_done_s;
    logic [DATA_W-1:0] srl_out_s;

    // Upstream may issue when idle, or when the held result leaves this cycle.
    always_comb begin
        case (state_r)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            SHIFT:   in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase
    end

    // Decode accept and whether it starts a multi-cycle shift.
    always_comb begin
        accept_s   = in_valid & in_ready;
        srl_load_s = accept_s & (funct == FUNCT_SRL) & (shamt != {SHAMT_W{1'b0}});
    end

    // Single-cycle datapath; a zero-distance SRL simply passes src2 through.
    always_comb begin
        sum_s     = src1 + src2;
        diff_s    = src1 - src2;
        alu_res_s = {DATA_W{1'b0}};
        alu_ovf_s = 1'b0;
        case (funct)
            FUNCT_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = add_overflow(src1[DATA_W-1], src2[DATA_W-1], sum_s[DATA_W-1]);
            end
            FUNCT_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = sub_overflow(src1[DATA_W-1], src2[DATA_W-1], diff_s[DATA_W-1]);
            end
            FUNCT_OR: begin
                alu_res_s = src1 | src2;
                alu_ovf_s = 1'b0;
            end
            FUNCT_SRL: begin
                alu_res_s = src2;
                alu_ovf_s = 1'b0;
            end
            default: begin
                alu_res_s = {DATA_W{1'b0}};
                alu_ovf_s = 1'b0;
            end
        endcase
    end

    alu_srl_iter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_srl (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (srl_load_s),
        .load_data  (src2),
        .load_shamt (shamt),
        .done       (srl_done_s),
        .shift_out  (srl_out_s)
    );

    // Control FSM and result registers; DONE holds everything until out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {DATA_W{1'b0}};
            zero_r      <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        if (srl_load_s) begin
                            state_r     <= SHIFT;
                            out_valid_r <= 1'b0;
                        end else begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= alu_res_s;
                            zero_r      <= (alu_res_s == {DATA_W{1'b0}});
                            overflow_r  <= alu_ovf_s;
                        end
                    end else if ((state_r == DONE) && out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= state_r;
                        out_valid_r <= out_valid_r;
                    end
                end
                SHIFT: begin
                    if (srl_done_s) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= srl_out_s;
                        zero_r      <= (srl_out_s == {DATA_W{1'b0}});
                        overflow_r  <= 1'b0;
                    end else begin
                        state_r     <= SHIFT;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases plus randomized traffic, all
// checked against a transaction-level reference model.
module tb_alu_exec_unit;

    localparam logic [5:0] F_ADD = 6'b001001;
    localparam logic [5:0] F_SUB = 6'b001010;
    localparam logic [5:0] F_OR  = 6'b010010;
    localparam logic [5:0] F_SRL = 6'b100010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  funct;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: a result pending for some cycles, or presented
    bit          mdl_valid;
    int          mdl_left;
    logic [31:0] mdl_res;
    logic        mdl_ovf;
    logic [31:0] pend_res;

    alu_exec_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .src1      (src1),
        .src2      (src2),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural meaning of each function code, in signed integer arithmetic.
    function automatic void ref_op(input logic [5:0] f, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh,
                                   output logic [31:0] r, output logic o);
        longint s;
        r = 32'd0;
        o = 1'b0;
        if (f == F_ADD) begin
            s = longint'($signed(a)) + longint'($signed(b));
            r = a + b;
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (f == F_SUB) begin
            s = longint'($signed(a)) - longint'($signed(b));
            r = a - b;
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (f == F_OR) begin
            r = a | b;
        end else if (f == F_SRL) begin
            r = b >> sh;
        end
    endfunction

    task automatic model_reset();
        mdl_valid = 1'b0;
        mdl_left  = 0;
        mdl_res   = 32'd0;
        mdl_ovf   = 1'b0;
        pend_res  = 32'd0;
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model over the edge.
    task automatic cycle(input logic iv, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic ordy);
        logic        exp_rdy;
        logic        acc;
        logic [31:0] r;
        logic        o;
        in_valid  = iv;
        funct     = f;
        src1      = a;
        src2      = b;
        shamt     = sh;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = (mdl_left > 0) ? 1'b0 : (mdl_valid ? ordy : 1'b1);
        check_val("in_ready", 64'(in_ready), 64'(exp_rdy));
        check_val("out_valid", 64'(out_valid), 64'(mdl_valid));
        if (mdl_valid) begin
            check_val("result", 64'(result), 64'(mdl_res));
            check_val("zero", 64'(zero), 64'(mdl_res == 32'd0));
            check_val("overflow", 64'(overflow), 64'(mdl_ovf));
        end
        acc = iv && exp_rdy;
        if (mdl_left > 0) begin
            mdl_left--;
            if (mdl_left == 0) begin
                mdl_valid = 1'b1;
                mdl_res   = pend_res;
                mdl_ovf   = 1'b0;
            end
        end else if (acc) begin
            ref_op(f, a, b, sh, r, o);
            if (f == F_SRL && sh != 5'd0) begin
                mdl_valid = 1'b0;
                mdl_left  = int'(sh);
                pend_res  = r;
            end else begin
                mdl_valid = 1'b1;
                mdl_res   = r;
                mdl_ovf   = o;
            end
        end else if (mdl_valid && ordy) begin
            mdl_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom, $urandom, $urandom, $urandom, ordy);
    endtask

    initial begin
        logic [5:0]  f;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;

        // reset held with busy-looking inputs
        model_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        funct     = F_ADD;
        src1      = $urandom;
        src2      = $urandom;
        shamt     = $urandom;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_result", 64'(result), 64'd0);
        check_val("rst_zero", 64'(zero), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADD overflow, then its result drains
        cycle(1'b1, F_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0, 1'b1);
        idle_cycles(2, 1'b1);
        // SUB to zero and an unknown code
        cycle(1'b1, F_SUB, 32'h12345678, 32'h12345678, 5'd0, 1'b1);
        cycle(1'b1, 6'b000000, 32'hDEADBEEF, 32'h00000001, 5'd3, 1'b1);
        idle_cycles(2, 1'b1);
        // SRL full-distance and zero-distance
        cycle(1'b1, F_SRL, 32'h12345678, 32'h80000000, 5'd31, 1'b1);
        idle_cycles(34, 1'b1);
        cycle(1'b1, F_SRL, 32'h0, 32'h80000000, 5'd0, 1'b1);
        idle_cycles(2, 1'b1);
        // OR under backpressure, with new offers that must be ignored
        cycle(1'b1, F_OR, 32'hF0F00000, 32'h00000F0F, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, F_ADD, $urandom, $urandom, 5'd0, 1'b0);
        idle_cycles(2, 1'b1);
        // three ADDs back-to-back
        cycle(1'b1, F_ADD, 32'd1, 32'd2, 5'd0, 1'b1);
        cycle(1'b1, F_ADD, 32'd10, 32'd20, 5'd0, 1'b1);
        cycle(1'b1, F_ADD, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b1);
        idle_cycles(2, 1'b1);

        // reset in the middle of a 20-bit shift
        cycle(1'b1, F_SRL, 32'd0, 32'hFFFF0000, 5'd20, 1'b1);
        idle_cycles(4, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", 64'(out_valid), 64'd0);
        check_val("midrst_in_ready", 64'(in_ready), 64'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(25, 1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0:       f = F_ADD;
                1:       f = F_SUB;
                2:       f = F_OR;
                3:       f = F_SRL;
                default: f = 6'($urandom);
            endcase
            sh = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 5) == 0) b = a;
            cycle(1'($urandom_range(0, 3) != 0), f, a, b, sh, 1'($urandom_range(0, 3) != 0));
        end
        idle_cycles(40, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 6-bit Funct code produced by the ALU control decoder, plus two register operands and a shift amount.
- Produces a registered result with zero/overflow flags.
- Uses a valid/ready handshake on both sides so the datapath can stall around the iterative shifter.
- Sits between the ALU control/operand-mux logic and the memory/writeback stage.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == DATA_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  unit can accept an operation this cycle
- funct  input  6  ALU operation code from ALU control
- src1  input  DATA_W  operand A
- src2  input  DATA_W  operand B; also the shift source for SRL
- shamt  input  SHAMT_W  shift amount for SRL
- out_valid  output  1  result/flags valid
- out_ready  input  1  downstream accepts the result
- result  output  DATA_W  registered result
- zero  output  1  result == 0
- overflow  output  1  signed overflow (ADD/SUB only)

Behaviour:
- Opcodes, fixed encodings:
  - 6'b001001 ADD: src1+src2
  - 6'b001010 SUB: src1-src2
  - 6'b010010 OR: src1|src2
  - 6'b100010 SRL: src2 logically shifted right by shamt
  - Any other code: result 0, overflow 0, zero 1. Never hangs.
- Reset, asynchronous, active-low, takes effect immediately:
  - state=IDLE; out_valid=0; result=0; zero=0; overflow=0; internal shift register and counter=0.
  - in_ready is combinational and therefore 1 while in IDLE.
- Reset mid-operation: an in-flight SRL or a pending DONE result is discarded; no output after release until a new accept.
- Accept condition: in_valid && in_ready at a clock edge. funct, src1, src2 and shamt are captured on that edge; later input changes are ignored.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On accept with ADD/SUB/OR/unknown: compute and register result/flags, go to DONE. Latency 1 cycle.
    - On accept with SRL and shamt!=0: load shift reg with src2, counter with shamt, go to SHIFT.
    - On accept with SRL and shamt==0: result=src2, go to DONE. Latency 1.
  - SHIFT: in_ready=0, out_valid=0.
    - Each cycle: shift reg >>= 1 (zero fill), counter -= 1.
    - When counter reaches 1 (the last shift is performed this cycle), write the shifted value to result and go to DONE.
    - SRL latency = 1 + shamt cycles; shamt=31 gives 32 cycles.
  - DONE: out_valid=1; result/zero/overflow held stable until handshake.
    - in_ready = out_ready, combinational.
    - out_ready=0: stay in DONE, outputs unchanged, in_valid ignored.
    - out_ready=1 and accept (back-to-back): a non-SRL op stays in DONE with the new result next cycle and out_valid remains 1. An SRL op goes to SHIFT (or stays in DONE if shamt==0).
    - out_ready=1, no accept: go to IDLE, out_valid=0 next cycle.
- Arithmetic:
  - ADD/SUB wrap modulo 2**DATA_W.
  - overflow for ADD: operands have the same sign and the result sign differs.
  - overflow for SUB: operand signs differ and the result sign differs from src1.
  - OR/SRL/unknown force overflow=0.
  - zero is computed from the registered result value.
- Max throughput: 1 op/cycle for non-SRL ops with out_ready held 1.

Decomposition:
- Shared package cpu_pkg:
  - localparams FUNCT_ADD=6'b001001, FUNCT_SUB=6'b001010, FUNCT_OR=6'b010010, FUNCT_SRL=6'b100010.
  - FSM state enum {IDLE, SHIFT, DONE}.
  - ALU control must import the same constants.
- One natural sub-module: alu_srl_iter, which holds the shift register, counter and done pulse. The combinational add/sub/or logic stays in the top module.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and random inputs -> out_valid=0, result=0, in_ready=1. Assert rst_n mid-SRL (shamt=20, cycle 5) -> out_valid=0 immediately and no result after release.
- ADD overflow: funct=001001, src1=32'h7FFFFFFF, src2=1, out_ready=1 -> one cycle later out_valid=1, result=32'h80000000, overflow=1, zero=0.
- SUB zero: funct=001010, src1=src2=32'h12345678 -> result=0, zero=1, overflow=0. Unknown funct=6'b000000 -> result=0, zero=1.
- SRL latency: funct=100010, src2=32'h80000000, shamt=31 -> in_ready=0 for 31 cycles, out_valid at cycle 32, result=1. With shamt=0 -> result=32'h80000000 after 1 cycle.
- Backpressure: OR src1=32'hF0F00000, src2=32'h00000F0F with out_ready=0 for 5 cycles -> result=32'hF0F00F0F held stable, in_ready=0 throughout, then releases on out_ready=1.
- Back-to-back: three ADDs streamed with in_valid=out_ready=1 -> out_valid stays 1 for three consecutive cycles with results in issue order, no bubbles.
